pss_track_controller: RTL and testbench

Sequencing controller for the three per-N_id_2 PSS correlator/peak-detector chains. It runs in one of two modes:
- **Acquisition:** all three correlators are enabled and the first peak fixes N_id_2 and sample timing.
- **Tracking:** only the matching correlator is enabled, and only inside a timing window around each expected SSB position.

It sits between the sample stream / peak detectors and the downstream SSB demodulator. It drives the correlators' `enable_i` and reports the locked N_id_2 and the timing events.

---
 rtl/pss_ctrl_pkg.sv | 33 +++
 rtl/pss_track_controller.sv | 163 ++++++++++++++++
 tb/tb_pss_track_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pss_ctrl_pkg.sv
// pss_ctrl_pkg
// Shared types and helpers for the PSS track controller.
//   state_e     : controller FSM state, 2-bit encoding fixed for debug visibility
//   N_ID_2_W    : width of an N_id_2 index
//   NUM_N_ID_2  : number of correlator chains (one per N_id_2)
package pss_ctrl_pkg;

  localparam int N_ID_2_W   = 2;
  localparam int NUM_N_ID_2 = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_WINDOW = 2'd3
  } state_e;

  // Index of the lowest set bit; lower N_id_2 wins when several chains fire at once.
  function automatic logic [N_ID_2_W-1:0] lowest_set(input logic [NUM_N_ID_2-1:0] v);
    logic [N_ID_2_W-1:0] idx;
    idx = '0;
    for (int i = NUM_N_ID_2 - 1; i >= 0; i--) begin
      if (v[i]) idx = N_ID_2_W'(i);
    end
    return idx;
  endfunction

  // One-hot correlator mask for a given N_id_2.
  function automatic logic [NUM_N_ID_2-1:0] onehot(input logic [N_ID_2_W-1:0] idx);
    return NUM_N_ID_2'(1) << idx;
  endfunction

endpackage

// File: rtl/pss_track_controller.sv
// pss_track_controller
// Sequences the three PSS correlator chains: all enabled while searching,
// then only the locked chain, and only inside a window around each expected
// SSB position while tracking.
// Ports:
//   clk_i, reset_i (sync, active-high)
//   enable_i          : run; low forces IDLE
//   s_axis_in_tvalid  : sample strobe, one timer tick per asserted cycle
//   peak_detected_i   : per-N_id_2 peak flags
//   correlator_en_o   : correlator enables
//   N_id_2_o          : locked N_id_2
//   N_id_2_valid_o    : high while tracking
//   peak_o / lost_o   : one-cycle event pulses
//   state_o           : FSM state for debug
module pss_track_controller
  import pss_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD      = 76800,
  parameter int unsigned WINDOW_HALF = 8,
  parameter int unsigned MAX_MISSES  = 3,
  parameter int unsigned CNT_W       = $clog2(PERIOD + WINDOW_HALF + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  s_axis_in_tvalid,
  input  logic [NUM_N_ID_2-1:0] peak_detected_i,
  output logic [NUM_N_ID_2-1:0] correlator_en_o,
  output logic [N_ID_2_W-1:0]   N_id_2_o,
  output logic                  N_id_2_valid_o,
  output logic                  peak_o,
  output logic                  lost_o,
  output logic [1:0]            state_o
);

  localparam int unsigned MISS_W = $clog2(MAX_MISSES + 1);

  localparam logic [CNT_W-1:0] CNT_OPEN  = CNT_W'(PERIOD - WINDOW_HALF);
  localparam logic [CNT_W-1:0] CNT_CLOSE = CNT_W'(PERIOD + WINDOW_HALF);
  // Restart value after a miss keeps the timer on the nominal SSB grid.
  localparam logic [CNT_W-1:0] CNT_MISS  = CNT_W'(WINDOW_HALF + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MISS_W-1:0]       miss_q, miss_d;
  logic [N_ID_2_W-1:0]     nid_q, nid_d;
  logic                    valid_q, valid_d;
  logic                    peak_q, peak_d;
  logic                    lost_q, lost_d;
  logic [NUM_N_ID_2-1:0]   en_q, en_d;

  logic [CNT_W-1:0]        cnt_inc;
  logic                    hit;
  logic                    last_miss;

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign hit       = |(peak_detected_i & onehot(nid_q));
  assign last_miss = (int'(miss_q) + 1) >= int'(MAX_MISSES);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    nid_d   = nid_q;
    valid_d = valid_q;
    peak_d  = 1'b0;
    lost_d  = 1'b0;

    if (!enable_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_SEARCH;

        ST_SEARCH: begin
          if (|peak_detected_i) begin
            nid_d   = lowest_set(peak_detected_i);
            cnt_d   = '0;
            miss_d  = '0;
            valid_d = 1'b1;
            peak_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end

        // Peaks here are late pipeline outputs from the previous hit; ignore them.
        ST_WAIT: begin
          if (s_axis_in_tvalid) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_OPEN) state_d = ST_WINDOW;
          end
        end

        ST_WINDOW: begin
          // A hit takes precedence over a simultaneous window close.
          if (hit) begin
            cnt_d   = '0;
            miss_d  = '0;
            peak_d  = 1'b1;
            state_d = ST_WAIT;
          end else if (s_axis_in_tvalid) begin
            if (cnt_q == CNT_CLOSE) begin
              cnt_d  = CNT_MISS;
              miss_d = miss_q + MISS_W'(1);
              if (last_miss) begin
                lost_d  = 1'b1;
                valid_d = 1'b0;
                state_d = ST_SEARCH;
              end else begin
                state_d = ST_WAIT;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    // Enables are derived from the next state so they change on the same edge as state.
    unique case (state_d)
      ST_SEARCH: en_d = '1;
      ST_WINDOW: en_d = onehot(nid_d);
      default:   en_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      miss_q  <= '0;
      nid_q   <= '0;
      valid_q <= 1'b0;
      peak_q  <= 1'b0;
      lost_q  <= 1'b0;
      en_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      nid_q   <= nid_d;
      valid_q <= valid_d;
      peak_q  <= peak_d;
      lost_q  <= lost_d;
      en_q    <= en_d;
    end
  end

  assign correlator_en_o = en_q;
  assign N_id_2_o        = nid_q;
  assign N_id_2_valid_o  = valid_q;
  assign peak_o          = peak_q;
  assign lost_o          = lost_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pss_track_controller.sv
// tb_pss_track_controller
// Directed bench for pss_track_controller with PERIOD=100, WINDOW_HALF=4,
// MAX_MISSES=3. Expected values are hand-derived from the sample count
// since the last accepted peak.
module tb_pss_track_controller;

  logic       clk;
  logic       reset_i;
  logic       enable_i;
  logic       tvalid;
  logic [2:0] peak_in;
  logic [2:0] en_o;
  logic [1:0] nid_o;
  logic       valid_o;
  logic       peak_o;
  logic       lost_o;
  logic [1:0] state_o;

  int checks   = 0;
  int failures = 0;

  pss_track_controller #(
    .PERIOD      (100),
    .WINDOW_HALF (4),
    .MAX_MISSES  (3)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .enable_i         (enable_i),
    .s_axis_in_tvalid (tvalid),
    .peak_detected_i  (peak_in),
    .correlator_en_o  (en_o),
    .N_id_2_o         (nid_o),
    .N_id_2_valid_o   (valid_o),
    .peak_o           (peak_o),
    .lost_o           (lost_o),
    .state_o          (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic [2:0] en,
                            input logic [1:0] nid, input logic vld, input logic pk,
                            input logic lst);
    check({tag, ".state"}, 32'(state_o), 32'(st));
    check({tag, ".en"},    32'(en_o),    32'(en));
    check({tag, ".nid"},   32'(nid_o),   32'(nid));
    check({tag, ".valid"}, 32'(valid_o), 32'(vld));
    check({tag, ".peak"},  32'(peak_o),  32'(pk));
    check({tag, ".lost"},  32'(lost_o),  32'(lst));
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_i  = 1'b1;
    enable_i = 1'b0;
    tvalid   = 1'b0;
    peak_in  = 3'b000;

    // 1. Reset and enable
    step_n(3);
    check_outs("reset", 2'd0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    reset_i  = 1'b0;
    enable_i = 1'b1;
    tvalid   = 1'b1;
    step();
    check_outs("enable", 2'd1, 3'b111, 2'd0, 1'b0, 1'b0, 1'b0);

    // 2. Acquisition: lowest set bit of 110 is N_id_2=1
    peak_in = 3'b110;
    step();
    check_outs("acq", 2'd2, 3'b000, 2'd1, 1'b1, 1'b1, 1'b0);
    peak_in = 3'b000;

    // 3. Tracking hit; cnt == number of valid edges since acquisition
    step_n(95);
    check_outs("pre_window", 2'd2, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0);
    tvalid = 1'b0;
    step_n(5);
    check("no_tvalid_hold.state", 32'(state_o), 32'd2);
    tvalid = 1'b1;
    step();                                       // cnt 96
    check_outs("window_open", 2'd3, 3'b010, 2'd1, 1'b1, 1'b0, 1'b0);
    step_n(2);                                    // cnt 98
    peak_in = 3'b001;
    step();                                       // cnt 99
    check_outs("wrong_bit", 2'd3, 3'b010, 2'd1, 1'b1, 1'b0, 1'b0);
    peak_in = 3'b000;
    step_n(2);                                    // cnt 101
    peak_in = 3'b010;
    step();
    check_outs("hit", 2'd2, 3'b000, 2'd1, 1'b1, 1'b1, 1'b0);

    // 5b. Peaks during WAIT are ignored
    step();                                       // cnt 1, matching bit still high
    check_outs("wait_peak1", 2'd2, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0);
    peak_in = 3'b111;
    step();                                       // cnt 2
    check_outs("wait_peak2", 2'd2, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0);
    peak_in = 3'b000;
    step_n(93);                                   // cnt 95
    check("rewin_pre.state", 32'(state_o), 32'd2);
    step();                                       // cnt 96
    check_outs("rewin_open", 2'd3, 3'b010, 2'd1, 1'b1, 1'b0, 1'b0);

    // 5a. Hit coincident with the closing valid cycle
    step_n(8);                                    // cnt 104
    check("close_edge.state", 32'(state_o), 32'd3);
    peak_in = 3'b010;
    step();
    check_outs("coincident", 2'd2, 3'b000, 2'd1, 1'b1, 1'b1, 1'b0);
    peak_in = 3'b000;

    // 4. Three misses; a miss counted above would make loss come one window early
    step_n(104);                                  // e=104, cnt 104
    check_outs("miss1_pre", 2'd3, 3'b010, 2'd1, 1'b1, 1'b0, 1'b0);
    step();                                       // e=105, cnt 5
    check_outs("miss1", 2'd2, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0);
    step_n(90);                                   // cnt 95
    check("miss1_wait.state", 32'(state_o), 32'd2);
    step();                                       // cnt 96
    check("miss1_reopen.state", 32'(state_o), 32'd3);
    step_n(8);                                    // e=204
    step();                                       // e=205
    check_outs("miss2", 2'd2, 3'b000, 2'd1, 1'b1, 1'b0, 1'b0);
    step_n(99);                                   // e=304
    check_outs("miss3_pre", 2'd3, 3'b010, 2'd1, 1'b1, 1'b0, 1'b0);
    step();                                       // e=305
    check_outs("lost", 2'd1, 3'b111, 2'd1, 1'b0, 1'b0, 1'b1);
    step();
    check_outs("lost_after", 2'd1, 3'b111, 2'd1, 1'b0, 1'b0, 1'b0);

    // 6a. Reacquire on bit 0, then drop enable inside WINDOW
    peak_in = 3'b001;
    step();
    check_outs("reacq0", 2'd2, 3'b000, 2'd0, 1'b1, 1'b1, 1'b0);
    peak_in = 3'b000;
    step_n(96);
    check_outs("win_nid0", 2'd3, 3'b001, 2'd0, 1'b1, 1'b0, 1'b0);
    step_n(2);
    enable_i = 1'b0;
    step();
    check_outs("abort_enable", 2'd0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    enable_i = 1'b1;
    step();
    check("reenable.state", 32'(state_o), 32'd1);

    // 6b. Reacquire on bit 2, then reset inside WINDOW with enable held high
    peak_in = 3'b100;
    step();
    check_outs("reacq2", 2'd2, 3'b000, 2'd2, 1'b1, 1'b1, 1'b0);
    peak_in = 3'b000;
    step_n(96);
    check_outs("win_nid2", 2'd3, 3'b100, 2'd2, 1'b1, 1'b0, 1'b0);
    reset_i = 1'b1;
    step();
    check_outs("abort_reset", 2'd0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    reset_i = 1'b0;
    step();
    check_outs("post_reset", 2'd1, 3'b111, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
